// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, MIPS opcode/funct values and datapath select codes.
// MC_ILLEGAL_TRAP_EN adds the absorbing TRAP state.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
`ifdef MC_ILLEGAL_TRAP_EN
    , ST_TRAP = 3'd5
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_IDLE = 6'b000000;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  localparam logic [1:0] WAC_RD = 2'b00;
  localparam logic [1:0] WAC_RT = 2'b01;
  localparam logic [1:0] WAC_RA = 2'b10;

  localparam logic [1:0] WDC_ALU = 2'b00;
  localparam logic [1:0] WDC_MEM = 2'b01;
  localparam logic [1:0] WDC_PC4 = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // One-hot instruction class; exactly one field is set for any opcode/funct
  typedef struct packed {
    logic add;
    logic sub;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_if.sv
// Control bus between the multi-cycle controller (master) and the datapath/memories (slave).
// MC_ILLEGAL_TRAP_EN adds the illegal flag.
interface mc_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_wac;
  logic [1:0]  reg_wdc;
  logic        alu_src;
  logic [5:0]  alu_control;
  logic [1:0]  ext;
  logic [31:0] retired;
  logic [2:0]  state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  modport master (
    input  opcode, funct, zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           reg_write, reg_wac, reg_wdc, alu_src, alu_control, ext, retired, state
`ifdef MC_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output opcode, funct, zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           reg_write, reg_wac, reg_wdc, alu_src, alu_control, ext, retired, state
`ifdef MC_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational one-hot instruction classifier shared by next-state and output logic.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  // Map opcode/funct to exactly one instruction class
  always_comb begin
    iclass = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  iclass.add     = 1'b1;
          FN_SUB:  iclass.sub     = 1'b1;
          FN_JR:   iclass.jr      = 1'b1;
          default: iclass.illegal = 1'b1;
        endcase
      end
      OP_ORI:  iclass.ori     = 1'b1;
      OP_LW:   iclass.lw      = 1'b1;
      OP_SW:   iclass.sw      = 1'b1;
      OP_BEQ:  iclass.beq     = 1'b1;
      OP_LUI:  iclass.lui     = 1'b1;
      OP_J:    iclass.j       = 1'b1;
      OP_JAL:  iclass.jal     = 1'b1;
      default: iclass.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Define MC_ILLEGAL_TRAP_EN to trap undecoded instructions instead of retiring them as nops.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mc_if.master bus
);

  state_t      state_r;
  state_t      next_s;
  logic [31:0] retired_r;
  logic        retire_s;
  iclass_t     iclass_s;

  logic        imem_req_s, dmem_req_s, dmem_we_s, ir_write_s, pc_write_s;
  logic        reg_write_s, alu_src_s, illegal_s;
  logic [1:0]  pc_src_s, reg_wac_s, reg_wdc_s, ext_s;
  logic [5:0]  alu_control_s;

  mc_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .iclass (iclass_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Any return to FETCH from a working state completes an instruction
  assign retire_s = (state_r != ST_FETCH) && (next_s == ST_FETCH);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= 32'd0;
    end else if (retire_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (bus.imem_ack) next_s = ST_DECODE;
        else              next_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (iclass_s.illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          next_s = ST_TRAP;
`else
          next_s = ST_FETCH;
`endif
        end else begin
          next_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (iclass_s.add || iclass_s.sub || iclass_s.ori || iclass_s.lui) next_s = ST_WB;
        else if (iclass_s.lw || iclass_s.sw)                               next_s = ST_MEM;
        else                                                               next_s = ST_FETCH;
      end
      ST_MEM: begin
        if (!bus.dmem_ack)    next_s = ST_MEM;
        else if (iclass_s.lw) next_s = ST_WB;
        else                  next_s = ST_FETCH;
      end
      ST_WB: next_s = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP: next_s = ST_TRAP;
`endif
      default: next_s = ST_FETCH;
    endcase
  end

  // Per-state datapath enables and selects
  always_comb begin
    imem_req_s    = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    pc_src_s      = PC_PLUS4;
    reg_write_s   = 1'b0;
    reg_wac_s     = WAC_RD;
    reg_wdc_s     = WDC_ALU;
    alu_src_s     = 1'b0;
    alu_control_s = ALU_IDLE;
    ext_s         = EXT_ZERO;
    illegal_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (bus.imem_ack) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write_s = 1'b0;
          pc_write_s = 1'b0;
        end
      end
      ST_DECODE: begin
      end
      ST_EXEC: begin
        if (iclass_s.add || iclass_s.lw || iclass_s.sw) alu_control_s = ALU_ADD;
        else if (iclass_s.sub || iclass_s.beq)          alu_control_s = ALU_SUB;
        else if (iclass_s.ori || iclass_s.lui)          alu_control_s = ALU_OR;
        else                                            alu_control_s = ALU_IDLE;
        alu_src_s = iclass_s.ori | iclass_s.lui | iclass_s.lw | iclass_s.sw;
        if (iclass_s.lw || iclass_s.sw) ext_s = EXT_SIGN;
        else if (iclass_s.lui)          ext_s = EXT_LUI;
        else                            ext_s = EXT_ZERO;
        if (iclass_s.beq) begin
          pc_write_s = bus.zero;
          pc_src_s   = PC_BRANCH;
        end else if (iclass_s.j || iclass_s.jal) begin
          pc_write_s = 1'b1;
          pc_src_s   = PC_JUMP;
        end else if (iclass_s.jr) begin
          pc_write_s = 1'b1;
          pc_src_s   = PC_RS;
        end else begin
          pc_write_s = 1'b0;
        end
        // jal links PC+4 into $31 in the same cycle as the jump
        if (iclass_s.jal) begin
          reg_write_s = 1'b1;
          reg_wac_s   = WAC_RA;
          reg_wdc_s   = WDC_PC4;
        end else begin
          reg_write_s = 1'b0;
        end
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = iclass_s.sw;
      end
      ST_WB: begin
        reg_write_s = 1'b1;
        if (iclass_s.lw) begin
          reg_wac_s = WAC_RT;
          reg_wdc_s = WDC_MEM;
        end else if (iclass_s.ori || iclass_s.lui) begin
          reg_wac_s = WAC_RT;
        end else begin
          reg_wac_s = WAC_RD;
        end
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP: illegal_s = 1'b1;
`endif
      default: begin
      end
    endcase
  end

  // Reset forces every enable low immediately, independent of the state register
  assign bus.imem_req    = rst_n & imem_req_s;
  assign bus.dmem_req    = rst_n & dmem_req_s;
  assign bus.dmem_we     = rst_n & dmem_we_s;
  assign bus.ir_write    = rst_n & ir_write_s;
  assign bus.pc_write    = rst_n & pc_write_s;
  assign bus.reg_write   = rst_n & reg_write_s;
  assign bus.alu_src     = rst_n & alu_src_s;
  assign bus.pc_src      = rst_n ? pc_src_s      : 2'b00;
  assign bus.reg_wac     = rst_n ? reg_wac_s     : 2'b00;
  assign bus.reg_wdc     = rst_n ? reg_wdc_s     : 2'b00;
  assign bus.ext         = rst_n ? ext_s         : 2'b00;
  assign bus.alu_control = rst_n ? alu_control_s : 6'b000000;
  assign bus.retired     = retired_r;
  assign bus.state       = state_r;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal     = rst_n & illegal_s;
`else
  logic unused_s;
  assign unused_s = illegal_s;
`endif

endmodule
